// File: rtl/tag_cam_4x6_pkg.sv
// Shared types and helpers for the 4-entry, 6-bit tag CAM.
// No logic state; pure types, sizes and combinational helper functions.
// No flow control of its own.
package tag_cam_4x6_pkg;

    localparam int TAG_W   = 6;
    localparam int ENTRIES = 4;
    localparam int IDX_W   = 2;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [ENTRIES-1:0] vec_t;
    typedef logic [2:0]         cnt_t;

    // Encode a one-hot (or all-zero) entry vector into an index; zero maps to 0.
    function automatic idx_t onehot_to_idx(vec_t oh);
        idx_t r;
        r = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (oh[i]) begin
                r = r | idx_t'(i);
            end
        end
        return r;
    endfunction

    // Count set bits of an entry vector (0..ENTRIES).
    function automatic cnt_t popcount(vec_t v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            c = c + cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/tag_cam_4x6_if.sv
// Request/result bundle between a CAM client and the tag CAM.
// Lookup results return one cycle after the request.
// No backpressure: requests are accepted every cycle.
interface tag_cam_4x6_if;
    import tag_cam_4x6_pkg::*;

    logic flush;
    logic wr_en;
    tag_t wr_tag;
    logic lk_en;
    tag_t lk_tag;
    logic hit_valid;
    logic hit;
    idx_t hit_idx;
    cnt_t occupancy;
    logic full;

    modport master (
        output flush, wr_en, wr_tag, lk_en, lk_tag,
        input  hit_valid, hit, hit_idx, occupancy, full
    );

    modport slave (
        input  flush, wr_en, wr_tag, lk_en, lk_tag,
        output hit_valid, hit, hit_idx, occupancy, full
    );
endinterface

// File: rtl/tag_cam_4x6_tag_entry.sv
// One CAM entry: tag register, valid bit, and two equality compares (lookup, insert).
// Write takes effect at the next edge; compares are combinational on stored state.
// No backpressure.
module tag_entry
    import tag_cam_4x6_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic we,
    input  tag_t d,
    input  tag_t lk_tag,
    input  tag_t wr_cmp,
    output logic valid,
    output logic lk_match,
    output logic wr_match
);

    tag_t tag_q;

    // Valid bit: reset and clear win over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (we) begin
            valid <= 1'b1;
        end
    end

    // Tag storage carries no reset; an invalid entry's tag is never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q <= d;
        end
    end

    // A match needs a valid entry and a zero XOR between stored and presented tag.
    assign lk_match = valid && ~|(tag_q ^ lk_tag);
    assign wr_match = valid && ~|(tag_q ^ wr_cmp);

endmodule

// File: rtl/tag_cam_4x6.sv
// 4-entry 6-bit tag CAM with insert (dup-suppress, fill-lowest, round-robin replace) and lookup.
// Insert visible 1 edge later; lookup result registered, 1 cycle latency, pre-edge contents.
// No backpressure: one insert and one lookup accepted every cycle.
module tag_cam_4x6
    import tag_cam_4x6_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    tag_cam_4x6_if.slave   bus
);

    vec_t vld;
    vec_t lk_match;
    vec_t wr_match;
    vec_t we;
    vec_t free_oh;
    idx_t vp;
    logic dup;
    logic insert;
    logic full_w;
    cnt_t occ_w;
    logic hit_valid_q;
    logic hit_q;
    idx_t hit_idx_q;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        tag_entry u_ent (
            .clk      (clk),
            .rst      (rst),
            .clr      (bus.flush),
            .we       (we[g]),
            .d        (bus.wr_tag),
            .lk_tag   (bus.lk_tag),
            .wr_cmp   (bus.wr_tag),
            .valid    (vld[g]),
            .lk_match (lk_match[g]),
            .wr_match (wr_match[g])
        );
    end

    assign occ_w  = popcount(vld);
    assign full_w = (occ_w == cnt_t'(ENTRIES));
    assign dup    = |wr_match;
    assign insert = bus.wr_en && !bus.flush && !dup;

    // Pick the lowest-index invalid entry as the fill target.
    always_comb begin
        logic found;
        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!vld[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Route the insert to the free slot, or to the victim when the array is full.
    always_comb begin
        we = '0;
        if (insert) begin
            if (full_w) begin
                we = vec_t'(1) << vp;
            end else begin
                we = free_oh;
            end
        end
    end

    // Victim pointer only advances on a replacement; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            vp <= '0;
        end else if (insert && full_w) begin
            vp <= vp + idx_t'(1);
        end
    end

    // Register the lookup result; idle cycles return all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            hit_valid_q <= bus.lk_en;
            hit_q       <= bus.lk_en && |lk_match;
            hit_idx_q   <= bus.lk_en ? onehot_to_idx(lk_match) : '0;
        end
    end

    assign bus.hit_valid = hit_valid_q;
    assign bus.hit       = hit_q;
    assign bus.hit_idx   = hit_idx_q;
    assign bus.occupancy = occ_w;
    assign bus.full      = full_w;

endmodule

// File: tb/tb_tag_cam_4x6.sv
module tb_tag_cam_4x6;
    import tag_cam_4x6_pkg::*;

    logic clk = 1'b0;
    logic rst;
    tag_cam_4x6_if bus();

    tag_cam_4x6 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: a plain table of (tag, valid) plus a replacement counter.
    int m_tag [4];
    bit m_val [4];
    int m_vp;
    int m_hv, m_hit, m_idx;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_find(input int t);
        for (int i = 0; i < 4; i++) begin
            if (m_val[i] && m_tag[i] == t) return i;
        end
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(m_val[i]);
        return c;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < 4; i++) begin
            if (!m_val[i]) return i;
        end
        return -1;
    endfunction

    // Model advance at each rising edge, using the inputs held across the edge.
    always @(posedge clk) begin
        int h;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
            m_vp = 0; m_hv = 0; m_hit = 0; m_idx = 0;
        end else begin
            h     = m_find(int'(bus.lk_tag));
            m_hv  = int'(bus.lk_en);
            m_hit = (bus.lk_en && h >= 0) ? 1 : 0;
            m_idx = (bus.lk_en && h >= 0) ? h : 0;
            if (bus.flush) begin
                for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
            end else if (bus.wr_en && m_find(int'(bus.wr_tag)) < 0) begin
                if (m_count() < 4) begin
                    h = m_first_free();
                    m_tag[h] = int'(bus.wr_tag);
                    m_val[h] = 1'b1;
                end else begin
                    m_tag[m_vp] = int'(bus.wr_tag);
                    m_vp = (m_vp + 1) % 4;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hit_valid", int'(bus.hit_valid), m_hv);
            chk("hit",       int'(bus.hit),       m_hit);
            chk("hit_idx",   int'(bus.hit_idx),   m_idx);
            chk("occupancy", int'(bus.occupancy), m_count());
            chk("full",      int'(bus.full),      (m_count() == 4) ? 1 : 0);
        end
    end

    task automatic cyc(input bit r, input bit f, input bit w, input int wt,
                       input bit l, input int lt);
        rst        = r;
        bus.flush  = f;
        bus.wr_en  = w;
        bus.wr_tag = tag_t'(wt);
        bus.lk_en  = l;
        bus.lk_tag = tag_t'(lt);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int t);
        cyc(0, 0, 1, t, 0, 0);
    endtask

    task automatic lk(input int t);
        cyc(0, 0, 0, 0, 1, t);
    endtask

    task automatic expect_hit(input string name, input int h, input int idx);
        chk({name, "_hv"},  int'(bus.hit_valid), 1);
        chk({name, "_hit"}, int'(bus.hit),       h);
        chk({name, "_idx"}, int'(bus.hit_idx),   idx);
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.wr_en = 1'b0; bus.wr_tag = '0;
        bus.lk_en = 1'b0; bus.lk_tag = '0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_hv",  int'(bus.hit_valid), 0);
        chk("rst_occ", int'(bus.occupancy), 0);
        chk("rst_full", int'(bus.full), 0);

        // Lookup on an empty array.
        lk('h2A);
        expect_hit("empty_lk", 0, 0);
        chk("empty_occ", int'(bus.occupancy), 0);

        // Fill in consecutive cycles.
        wr('h01); chk("fill_occ1", int'(bus.occupancy), 1);
        wr('h3F); chk("fill_occ2", int'(bus.occupancy), 2);
        wr('h15); chk("fill_occ3", int'(bus.occupancy), 3);
        wr('h2A); chk("fill_occ4", int'(bus.occupancy), 4);
        chk("fill_full", int'(bus.full), 1);
        chk("model_occ", m_count(), 4);
        lk('h15);
        expect_hit("fill_lk15", 1, 2);

        // Duplicate suppression from a fresh array.
        cyc(0, 1, 0, 0, 0, 0);
        chk("flush_occ", int'(bus.occupancy), 0);
        wr('h01);
        wr('h3F); chk("dup_occ_a", int'(bus.occupancy), 2);
        wr('h3F); chk("dup_occ_b", int'(bus.occupancy), 2);
        lk('h3F);
        expect_hit("dup_lk", 1, 1);

        // Full array, victim at 0: five replacements wrap the pointer once.
        wr('h15); wr('h2A);
        chk("repl_full", int'(bus.full), 1);
        wr('h07); wr('h08); wr('h09); wr('h0A); wr('h0B);
        lk('h0B); expect_hit("repl_e0", 1, 0);
        lk('h08); expect_hit("repl_e1", 1, 1);
        lk('h09); expect_hit("repl_e2", 1, 2);
        lk('h0A); expect_hit("repl_e3", 1, 3);
        lk('h01); expect_hit("repl_old", 0, 0);
        // Victim pointer now 1: the next replacement lands on entry 1.
        wr('h0C);
        lk('h0C); expect_hit("repl_vp1", 1, 1);
        lk('h08); expect_hit("repl_gone", 0, 0);

        // Same-cycle write and lookup sees pre-write state.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 'h11, 1, 'h11);
        expect_hit("wr_lk_same", 0, 0);
        lk('h11);
        expect_hit("wr_lk_next", 1, 0);

        // Flush beats a concurrent write.
        cyc(0, 1, 1, 'h22, 0, 0);
        chk("flush_wr_occ", int'(bus.occupancy), 0);
        lk('h22); expect_hit("flush_wr_lk", 0, 0);

        // Reset mid-operation kills an in-flight lookup and the contents.
        wr('h31); wr('h32); wr('h33); wr('h34);
        chk("pre_rst_full", int'(bus.full), 1);
        cyc(1, 0, 0, 0, 1, 'h31);
        chk("rst_mid_hv",  int'(bus.hit_valid), 0);
        chk("rst_mid_occ", int'(bus.occupancy), 0);
        lk('h31); expect_hit("rst_mid_lk", 0, 0);

        // Randomized traffic over a small tag space to force hits, dups and replacements.
        for (int n = 0; n < 3000; n++) begin
            bit r, f, w, l;
            int wt, lt;
            r  = ($urandom_range(0, 63) == 0);
            f  = ($urandom_range(0, 15) == 0);
            w  = ($urandom_range(0, 1) == 1);
            l  = ($urandom_range(0, 3) != 0);
            wt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
            lt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
            cyc(r, f, w, wt, l, lt);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_cam_4x6.md
# tag_cam_4x6

Four-entry, 6-bit tag store with registered associative lookup. It is the write/insert side that fills the tag array, plus the match path that reports whether a presented tag is held and at which index. It sits alongside the equality-compare logic in the cache/TLB datapath. Writers insert tags; readers query them one cycle later.

## Interface
Parameters:
- `ENTRIES`, 4: number of tag entries. Fixed at 4 for this revision; index width 2.
- `TAG_W`, 6: tag width in bits.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `flush`, in, 1: clear all valid bits.
- `wr_en`, in, 1: insert request.
- `wr_tag`, in, 6: tag to insert.
- `lk_en`, in, 1: lookup request.
- `lk_tag`, in, 6: tag to look up.
- `hit_valid`, out, 1: lookup result is valid this cycle.
- `hit`, out, 1: the looked-up tag is present.
- `hit_idx`, out, 2: index of the matching entry; 0 on miss.
- `occupancy`, out, 3: number of valid entries, 0–4.
- `full`, out, 1: `occupancy == 4`.

## Operation
- Each entry holds a 6-bit tag and a valid bit.
- A match for an entry requires the valid bit set and all 6 bits equal, i.e. the XOR-reduce of the two tags is 0.
- Insert when `wr_en`=1 and `flush`=0:
  - **Duplicate.** If `wr_tag` matches any valid entry, there is no state change.
  - **Not full.** Otherwise, if `full`=0, write to the lowest-index invalid entry and set its valid bit. The victim pointer is unchanged.
  - **Full.** Otherwise, overwrite the entry at victim pointer `vp`, then `vp <= vp + 1`, wrapping 3→0.
- Flush:
  - `flush`=1 clears all valid bits. `vp` is unchanged.
  - `flush` has priority over `wr_en`; the write is dropped.
- Lookup:
  - `lk_en`=1 samples `lk_tag` against the array contents as they stand before this edge's updates.
  - Result is registered into `hit_valid`/`hit`/`hit_idx`.
  - When `lk_en`=0, the next cycle has `hit_valid`=0, `hit`=0 and `hit_idx`=0.
- At most one entry can match, because of duplicate suppression. `hit_idx` is the encoded one-hot match.
- Tags in invalid entries never produce a hit.
- `occupancy` and `full` are derived combinationally from the registered valid bits.

## Timing
- Reset (`rst`=1 at an edge):
  - All valid bits = 0, `vp` = 0.
  - `hit_valid` = 0, `hit` = 0, `hit_idx` = 0.
  - Hence `occupancy` = 0 and `full` = 0.
  - Tag contents are don't-care.
- Reset mid-operation overrides `flush`, `wr_en` and `lk_en` in the same cycle. A lookup issued in the reset cycle produces no result.
- Insert latency is 1 edge: a tag written at edge N is visible to a lookup sampled at edge N+1 or later.
- Lookup latency is 1: `lk_en` high in the cycle before edge N gives the result valid in the cycle after edge N.
- Same-cycle write and lookup of the same tag returns miss, because the lookup sees pre-write state. Same-cycle flush and lookup returns the pre-flush result.
- Back-to-back lookups every cycle are supported with no bubbles. Inserts every cycle are supported.

## Structure
- Shared package holds:
  - `TAG_W`=6, `ENTRIES`=4, `IDX_W`=2.
  - Type `tag_t` (6-bit).
  - Type `idx_t` (2-bit).
- Sub-module `tag_entry`: one tag register, one valid bit, a write-enable, a clear, and a 6-bit equality compare producing `match`.
  - It is instantiated twice per entry: once for the lookup compare and once for the duplicate compare on `wr_tag`. Alternatively, a single `tag_entry` with two compare ports.
- Top level owns:
  - lowest-invalid priority select
  - victim pointer counter
  - one-hot-to-index encoder
  - output registers
  - popcount

## Test plan
- **Reset, then lookup.** Reset, then lookup `6'h2A` → `hit_valid`=1, `hit`=0, `hit_idx`=0, `occupancy`=0.
- **Fill and query.** Insert `6'h01`, `6'h3F`, `6'h15`, `6'h2A` in consecutive cycles → `occupancy` 1,2,3,4 and `full`=1. Lookup `6'h15` → `hit`=1, `hit_idx`=2.
- **Duplicate suppression.** Insert `6'h3F` twice → `occupancy` stays 2. Lookup `6'h3F` → `hit_idx`=1.
- **Replacement wrap.** Array full with `vp`=0, insert `6'h07`, `6'h08`, `6'h09`, `6'h0A`, `6'h0B`:
  - entries end as 0:`0B`, 1:`08`, 2:`09`, 3:`0A`, and `vp`=1.
  - lookup `6'h01` → miss.
- **Simultaneous events:**
  - Write `6'h11` and lookup `6'h11` in the same cycle → miss; lookup next cycle → hit.
  - `flush` together with `wr_en` `6'h22` → `occupancy`=0 after the edge.
- **Reset mid-operation.** Array full and `lk_en`=1 with `rst`=1 → next cycle `hit_valid`=0 and `occupancy`=0. A lookup of any prior tag afterwards → miss.
